// File: rtl/pulse_generator.sv
`timescale 1ns/1ps
// pulse_generator
//   Turns one accepted command into a clean rectangular pulse on out_pulse with
//   programmable high time (cmd_width, 0 treated as 1) and trailing low time
//   (cmd_gap). A mandatory IDLE cycle separates consecutive pulses, so each
//   pulse always has exactly one rising and one falling edge.
//
//   Optional feature macro: PULSE_GEN_REPEAT_EN
//     Adds cmd_repeat (N extra pulses, N+1 total). Between repeated pulses the
//     low time is max(gap,1). done fires only after the final pulse.
//
// Ports
//   clk         in   clock, all logic on posedge
//   rst_n       in   synchronous active-low reset
//   cmd_valid   in   command offered
//   cmd_ready   out  command can be accepted (IDLE and not in reset)
//   cmd_width   in   high time in cycles (0 -> 1)
//   cmd_gap     in   extra low time after the pulse
//   cmd_repeat  in   extra pulse count (only with PULSE_GEN_REPEAT_EN)
//   out_pulse   out  registered pulse line
//   busy        out  high while in HIGH or GAP
//   done        out  one-cycle strobe on the first IDLE cycle after a command
module pulse_generator #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_width,
    input  logic [CNT_W-1:0] cmd_gap,
`ifdef PULSE_GEN_REPEAT_EN
    input  logic [CNT_W-1:0] cmd_repeat,
`endif
    output logic             out_pulse,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             out_pulse_q, out_pulse_d;
    logic             done_q, done_d;
    logic             accept;
`ifdef PULSE_GEN_REPEAT_EN
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] rep_q, rep_d;
`endif

    assign cmd_ready = (state_q == ST_IDLE) & rst_n;
    assign accept    = cmd_valid & cmd_ready;
    assign out_pulse = out_pulse_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
`ifdef PULSE_GEN_REPEAT_EN
        width_d = width_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HIGH;
                    cnt_d   = (cmd_width == '0) ? '0 : cmd_width - ONE;
                    gap_d   = cmd_gap;
`ifdef PULSE_GEN_REPEAT_EN
                    width_d = cmd_width;
                    rep_d   = cmd_repeat;
`endif
                end
            end
            ST_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
`ifdef PULSE_GEN_REPEAT_EN
                end else if (gap_q != '0 || rep_q != '0) begin
                    // Zero gap is stretched to one low cycle while repeats remain.
                    state_d = ST_GAP;
                    cnt_d   = (gap_q == '0) ? '0 : gap_q - ONE;
`else
                end else if (gap_q != '0) begin
                    state_d = ST_GAP;
                    cnt_d   = gap_q - ONE;
`endif
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
`ifdef PULSE_GEN_REPEAT_EN
                end else if (rep_q != '0) begin
                    state_d = ST_HIGH;
                    rep_d   = rep_q - ONE;
                    cnt_d   = (width_q == '0) ? '0 : width_q - ONE;
`endif
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Line level follows the next state so it is a clean flop output.
        out_pulse_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            out_pulse_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PULSE_GEN_REPEAT_EN
            width_q     <= '0;
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            out_pulse_q <= out_pulse_d;
            done_q      <= done_d;
`ifdef PULSE_GEN_REPEAT_EN
            width_q     <= width_d;
            rep_q       <= rep_d;
`endif
        end
    end

endmodule
